// File: rtl/dot4_accumulator.sv
// Streaming 4-bit dot-product engine wrapped around an external 4x4 multiplier.
// Optional build macro DOT4_SAT_EN: clamp the accumulator instead of wrapping.
module dot4_accumulator #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {StAcc, StFlush, StHold} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q;
    logic [ACC_W-1:0] acc_q, acc_add;
    logic             ovf_q;
    logic             p_vld_q;
    logic [3:0]       mul_a_q, mul_b_q;
    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             complete;

    assign in_ready  = (state_q == StAcc) && !rst;
    assign out_valid = (state_q == StHold);
    assign accept    = in_valid && in_ready;
    assign complete  = out_valid && out_ready;

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_p};

`ifdef DOT4_SAT_EN
    assign acc_add = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc: begin
                if (accept && (cnt_q == 8'(LEN - 1))) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StHold;
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            p_vld_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            p_vld_q <= accept;
            if (accept) begin
                mul_a_q <= a;
                mul_b_q <= b;
            end
            if (complete) begin
                cnt_q <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (accept) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (p_vld_q) begin
                    acc_q <= acc_add;
                    if (sum_ext[ACC_W]) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign out_sum = acc_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_dot4_accumulator.sv
// Directed bench: four instances (LEN = 8, 4, 20, 1; ACC_W = 12) each fed by a behavioural
// multiplier; expected sums are hand-computed constants.
module tb_dot4_accumulator;

    localparam int unsigned NI = 4;

    logic        clk;
    logic        rst  [NI];
    logic        iv   [NI];
    logic        ir   [NI];
    logic [3:0]  av   [NI];
    logic [3:0]  bv   [NI];
    logic [3:0]  ma   [NI];
    logic [3:0]  mb   [NI];
    logic [7:0]  mp   [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic [11:0] sum  [NI];
    logic        ovf  [NI];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign mp[g] = 8'(ma[g]) * 8'(mb[g]);
        dot4_accumulator #(
            .LEN  ((g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 20 : 1),
            .ACC_W(12)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .a        (av[g]),
            .b        (bv[g]),
            .mul_a    (ma[g]),
            .mul_b    (mb[g]),
            .mul_p    (mp[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_sum  (sum[g]),
            .out_ovf  (ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for exactly one edge; back-to-back calls give an unbroken stream.
    task automatic push(input int k, input logic [3:0] x, input logic [3:0] y);
        check("push_ready", 32'(ir[k]), 1);
        iv[k] = 1'b1;
        av[k] = x;
        bv[k] = y;
        step();
        iv[k] = 1'b0;
    endtask

    // Called right after the last accepting edge: one FLUSH cycle, then HOLD.
    task automatic expect_result(input int k, input int exp_sum, input int exp_ovf);
        check("flush_valid", 32'(ov[k]), 0);
        check("flush_ready", 32'(ir[k]), 0);
        step();
        check("hold_valid", 32'(ov[k]), 1);
        check("hold_ready", 32'(ir[k]), 0);
        check("hold_sum", 32'(sum[k]), 32'(exp_sum));
        check("hold_ovf", 32'(ovf[k]), 32'(exp_ovf));
    endtask

    task automatic complete(input int k);
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        check("done_valid", 32'(ov[k]), 0);
        check("done_ready", 32'(ir[k]), 1);
        check("done_sum", 32'(sum[k]), 0);
        check("done_ovf", 32'(ovf[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0; av[k] = '0; bv[k] = '0;
        end
        step();
        step();
        for (int k = 0; k < NI; k++) begin
            check("rst_ready", 32'(ir[k]), 0);
            check("rst_valid", 32'(ov[k]), 0);
            check("rst_sum", 32'(sum[k]), 0);
            check("rst_ovf", 32'(ovf[k]), 0);
            check("rst_mula", 32'(ma[k]), 0);
            check("rst_mulb", 32'(mb[k]), 0);
            rst[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NI; k++) check("post_rst_ready", 32'(ir[k]), 1);
        step();

        // LEN=8: 8 x (3,5) = 120
        for (int i = 0; i < 8; i++) push(0, 4'd3, 4'd5);
        expect_result(0, 120, 0);

        // Stall in HOLD with operands offered; nothing may be accepted.
        iv[0] = 1'b1; av[0] = 4'd15; bv[0] = 4'd15;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(ov[0]), 1);
            check("stall_sum", 32'(sum[0]), 120);
            check("stall_ready", 32'(ir[0]), 0);
            check("stall_mula", 32'(ma[0]), 3);
        end
        iv[0] = 1'b0;
        complete(0);

        // Next vector starts from zero: 8 x (1,1) = 8
        for (int i = 0; i < 8; i++) push(0, 4'd1, 4'd1);
        expect_result(0, 8, 0);
        complete(0);

        // Abort after 5 accepts, then a full (2,2) vector = 32
        for (int i = 0; i < 5; i++) push(0, 4'd7, 4'd7);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        #1;
        check("abort_ready", 32'(ir[0]), 1);
        check("abort_valid", 32'(ov[0]), 0);
        check("abort_sum", 32'(sum[0]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_idle_valid", 32'(ov[0]), 0);
            check("abort_idle_sum", 32'(sum[0]), 0);
        end
        for (int i = 0; i < 8; i++) push(0, 4'd2, 4'd2);
        expect_result(0, 32, 0);
        complete(0);

        // LEN=4 with a 3-cycle gap: 225 + 2 + 0 + 49 = 276
        push(1, 4'd15, 4'd15);
        push(1, 4'd1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            check("gap_ready", 32'(ir[1]), 1);
            check("gap_valid", 32'(ov[1]), 0);
            step();
        end
        check("gap_sum", 32'(sum[1]), 227);
        push(1, 4'd0, 4'd9);
        push(1, 4'd7, 4'd7);
        expect_result(1, 276, 0);
        complete(1);

        // LEN=20 x (15,15): true sum 4500
        for (int i = 0; i < 20; i++) push(2, 4'd15, 4'd15);
`ifdef DOT4_SAT_EN
        expect_result(2, 4095, 1);
`else
        expect_result(2, 404, 1);
`endif
        complete(2);

        // LEN=1: (9,11) = 99
        push(3, 4'd9, 4'd11);
        expect_result(3, 99, 0);
        complete(3);
        push(3, 4'd4, 4'd4);
        expect_result(3, 16, 0);
        complete(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
